// File: rtl/vx_commit_collector.sv
// Per-issue-slot commit collector: round-robin arbitration over execute units with
// multi-packet locking, a registered writeback port and retire reporting.
// Optional perf counters are enabled by defining VX_COMMIT_PERF_EN.
module vx_commit_collector #(
  parameter int NUM_UNITS   = 5,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 6
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_UNITS-1:0]                in_valid,
  output logic [NUM_UNITS-1:0]                in_ready,
  input  logic [NUM_UNITS*NW_BITS-1:0]        in_wid,
  input  logic [NUM_UNITS*NUM_THREADS-1:0]    in_tmask,
  input  logic [NUM_UNITS-1:0]                in_wb,
  input  logic [NUM_UNITS*NR_BITS-1:0]        in_rd,
  input  logic [NUM_UNITS*NUM_THREADS*XLEN-1:0] in_data,
  input  logic [NUM_UNITS-1:0]                in_sop,
  input  logic [NUM_UNITS-1:0]                in_eop,
  output logic                                wb_valid,
  output logic [NW_BITS-1:0]                  wb_wid,
  output logic [NR_BITS-1:0]                  wb_rd,
  output logic [NUM_THREADS-1:0]              wb_tmask,
  output logic [NUM_THREADS*XLEN-1:0]         wb_data,
  output logic                                commit_valid,
  output logic [NW_BITS-1:0]                  commit_wid,
  output logic [$clog2(NUM_THREADS+1)-1:0]    commit_size
`ifdef VX_COMMIT_PERF_EN
  ,
  output logic [63:0]                         perf_instret,
  output logic [63:0]                         perf_stall
`endif
);

  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int CW = $clog2(NUM_THREADS + 1);
  localparam int DW = NUM_THREADS * XLEN;

  function automatic logic [CW-1:0] popcount(input logic [NUM_THREADS-1:0] mask);
    logic [CW-1:0] cnt;
    cnt = {CW{1'b0}};
    for (int i = 0; i < NUM_THREADS; i++) begin
      cnt = cnt + CW'(mask[i]);
    end
    return cnt;
  endfunction

  logic [UW-1:0]        rr_ptr_r;
  logic [UW-1:0]        locked_unit_r;
  logic                 lock_r;
  logic                 grant_found_s;
  logic [UW-1:0]        grant_idx_s;
  logic [NUM_UNITS-1:0] grant_oh_s;
  logic                 accept_s;
  logic                 sel_wb_s;
  logic                 sel_sop_s;
  logic                 sel_eop_s;
  logic [NW_BITS-1:0]   sel_wid_s;
  logic [NR_BITS-1:0]   sel_rd_s;
  logic [NUM_THREADS-1:0] sel_tmask_s;
  logic [DW-1:0]        sel_data_s;

  // Grant selection: the locked unit only, otherwise first valid unit from rr_ptr upward
  always_comb begin
    int  cand;
    logic hit;
    cand          = 0;
    hit           = 1'b0;
    grant_found_s = 1'b0;
    grant_idx_s   = {UW{1'b0}};
    if (lock_r) begin
      grant_found_s = in_valid[locked_unit_r];
      grant_idx_s   = locked_unit_r;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        cand          = (int'(rr_ptr_r) + i) % NUM_UNITS;
        hit           = in_valid[cand[UW-1:0]] & ~grant_found_s;
        grant_idx_s   = hit ? cand[UW-1:0] : grant_idx_s;
        grant_found_s = grant_found_s | hit;
      end
    end
  end

  // One-hot grant and AND-OR mux of the granted unit's packet fields
  always_comb begin
    grant_oh_s  = {NUM_UNITS{1'b0}};
    sel_wb_s    = 1'b0;
    sel_sop_s   = 1'b0;
    sel_eop_s   = 1'b0;
    sel_wid_s   = {NW_BITS{1'b0}};
    sel_rd_s    = {NR_BITS{1'b0}};
    sel_tmask_s = {NUM_THREADS{1'b0}};
    sel_data_s  = {DW{1'b0}};
    for (int u = 0; u < NUM_UNITS; u++) begin
      grant_oh_s[u] = grant_found_s & (grant_idx_s == UW'(u));
      sel_wb_s      = sel_wb_s    | (in_wb[u]  & grant_oh_s[u]);
      sel_sop_s     = sel_sop_s   | (in_sop[u] & grant_oh_s[u]);
      sel_eop_s     = sel_eop_s   | (in_eop[u] & grant_oh_s[u]);
      sel_wid_s     = sel_wid_s   | (in_wid[u*NW_BITS +: NW_BITS] & {NW_BITS{grant_oh_s[u]}});
      sel_rd_s      = sel_rd_s    | (in_rd[u*NR_BITS +: NR_BITS] & {NR_BITS{grant_oh_s[u]}});
      sel_tmask_s   = sel_tmask_s | (in_tmask[u*NUM_THREADS +: NUM_THREADS] & {NUM_THREADS{grant_oh_s[u]}});
      sel_data_s    = sel_data_s  | (in_data[u*DW +: DW] & {DW{grant_oh_s[u]}});
    end
  end

  // Nothing is accepted while reset is held, so ready stays low then too
  assign in_ready = grant_oh_s & {NUM_UNITS{reset}};
  assign accept_s = grant_found_s & reset;

  // Arbitration state: rotate after a completed instruction, lock across sop..eop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_r      <= {UW{1'b0}};
      lock_r        <= 1'b0;
      locked_unit_r <= {UW{1'b0}};
    end else if (accept_s) begin
      if (sel_eop_s) begin
        lock_r   <= 1'b0;
        rr_ptr_r <= (grant_idx_s == UW'(NUM_UNITS - 1)) ? {UW{1'b0}} : grant_idx_s + UW'(1);
      end else if (sel_sop_s) begin
        lock_r        <= 1'b1;
        locked_unit_r <= grant_idx_s;
      end
    end
  end

  // Registered writeback and retire outputs; strobes are single-cycle pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid     <= 1'b0;
      wb_wid       <= {NW_BITS{1'b0}};
      wb_rd        <= {NR_BITS{1'b0}};
      wb_tmask     <= {NUM_THREADS{1'b0}};
      wb_data      <= {DW{1'b0}};
      commit_valid <= 1'b0;
      commit_wid   <= {NW_BITS{1'b0}};
      commit_size  <= {CW{1'b0}};
    end else begin
      wb_valid     <= accept_s & sel_wb_s;
      commit_valid <= accept_s & sel_eop_s;
      if (accept_s) begin
        wb_wid   <= sel_wid_s;
        wb_rd    <= sel_rd_s;
        wb_tmask <= sel_tmask_s;
        wb_data  <= sel_data_s;
      end
      if (accept_s && sel_eop_s) begin
        commit_wid  <= sel_wid_s;
        commit_size <= popcount(sel_tmask_s);
      end
    end
  end

`ifdef VX_COMMIT_PERF_EN
  function automatic logic [63:0] sat_add(input logic [63:0] acc, input logic [63:0] inc);
    logic [64:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    return sum[64] ? {64{1'b1}} : sum[63:0];
  endfunction

  logic stall_s;
  assign stall_s = |(in_valid & ~in_ready);

  // Saturating retire and stall counters; instret tracks the commit being registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_instret <= 64'd0;
      perf_stall   <= 64'd0;
    end else begin
      if (accept_s && sel_eop_s) begin
        perf_instret <= sat_add(perf_instret, 64'(popcount(sel_tmask_s)));
      end
      if (stall_s) begin
        perf_stall <= sat_add(perf_stall, 64'd1);
      end
    end
  end
`endif

endmodule

// File: doc/vx_commit_collector.md
# vx_commit_collector

Per-issue-slot commit collector that sits downstream of the execute stage. It accepts commit-interface packets from every execute unit (ALU, LSU, FPU, TCU, SFU) for one issue slot and arbitrates them round-robin. It keeps multi-packet instructions contiguous and drives a single registered writeback port toward the register file. It also reports retired-instruction counts to the scheduler and performance logic.

## Interface
- NUM_UNITS, 5, execute units feeding this slot (index = EX_* id)
- NUM_THREADS, 4, lanes per packet
- XLEN, 32, data width per lane
- NW_BITS, 2, warp-id width
- NR_BITS, 6, register-id width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  NUM_UNITS  per-unit packet valid
- in_ready  out  NUM_UNITS  per-unit accept; asserted only for the granted unit
- in_wid  in  NUM_UNITS*NW_BITS  warp id
- in_tmask  in  NUM_UNITS*NUM_THREADS  thread mask
- in_wb  in  NUM_UNITS  writeback required
- in_rd  in  NUM_UNITS*NR_BITS  destination register
- in_data  in  NUM_UNITS*NUM_THREADS*XLEN  result data
- in_sop, in_eop  in  NUM_UNITS each  start/end of instruction
- wb_valid  out  1  registered writeback strobe (in_wb of accepted packet)
- wb_wid, wb_rd, wb_tmask, wb_data  out  widths as inputs  registered writeback fields
- commit_valid  out  1  one instruction retired this cycle (accepted packet had eop)
- commit_wid  out  NW_BITS  warp of retired instruction
- commit_size  out  $clog2(NUM_THREADS+1)  popcount of tmask at eop

## Operation
- Arbiter: round-robin over in_valid, starting at rr_ptr; grant one unit per cycle; output side has no backpressure, so a granted valid packet is always accepted (in_ready[g]=1).
- rr_ptr: after an accepted eop packet from unit g, rr_ptr <= (g+1) mod NUM_UNITS; otherwise unchanged.
- Packet lock: an accepted packet with sop=1, eop=0 sets lock and locked_unit=g; while locked, only locked_unit may be granted, other units see in_ready=0 even if valid; lock clears on the accepted eop packet from locked_unit. A packet with sop=eop=1 never locks.
- Locked unit idle (in_valid low): no grant, no output, lock held.
- wb_valid = accepted & in_wb; packets with in_wb=0 still retire (commit_valid on eop) but produce no writeback.
- commit_size = popcount(in_tmask) of the eop packet; tmask=0 gives size 0 and commit_valid still 1.
- Reset: wb_valid=0, commit_valid=0, all data fields 0, commit_size=0, rr_ptr=0, lock=0, in_ready=0; counters 0.

## Timing
- Combinational grant/in_ready from in_valid, rr_ptr, lock (same cycle).
- Accepted packet appears on wb_*/commit_* exactly 1 cycle later; outputs are single-cycle pulses, deasserted the next cycle if nothing is accepted.
- Throughput: 1 packet/cycle sustained.
- Reset mid-packet: lock dropped immediately (async), any in-flight registered output cleared; upstream units are expected to be reset together.
- NUM_UNITS=1: arbiter degenerates to pass-through with 1-cycle register; lock logic still applies.

## Configuration
- VX_COMMIT_PERF_EN defined: adds outputs perf_instret (64-bit, += commit_size on each commit_valid cycle) and perf_stall (64-bit, +1 each cycle some unit has in_valid=1 but in_ready=0); both saturate at all-ones, both reset to 0.
- Undefined: perf ports and counters absent; functional behaviour identical.

## Test plan
- Single unit 2 sends sop=eop=1, wb=1, wid=3, rd=5, tmask=4'b1011 -> next cycle wb_valid=1, wb_rd=5, commit_valid=1, commit_wid=3, commit_size=3.
- All 5 units valid continuously with single-packet instructions, rr_ptr=0 -> grant order 0,1,2,3,4,0; no unit granted twice before others.
- Unit 1 sends 3-packet instruction (sop,-,eop) while unit 0 valid -> unit 1 packets on 3 consecutive cycles, in_ready[0]=0 throughout, commit_valid only on third; unit 0 granted next.
- Locked unit 3 drops valid for 2 cycles mid-instruction -> no outputs, unit 4 still blocked; resumes on revalidation.
- in_wb=0, eop=1, tmask=0 -> wb_valid=0, commit_valid=1, commit_size=0.
- Assert reset during locked packet -> outputs 0 immediately; after release unit 0 granted first; with VX_COMMIT_PERF_EN perf_instret=0.
